// File: rtl/control_unit_fsm.sv
// control_unit_fsm: start/fetch/decode/execute controller for the 8-bit accumulator DataPath.
// Define CU_ENTER_WAIT_EN to make INPUT wait for the operator enter key.
module control_unit_fsm #(
  parameter int OP_W = 3,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            clear,
  input  logic [OP_W-1:0] IR75,
  input  logic            Aeq0,
  input  logic            Apos,
  input  logic            enter,
  output logic            IRload,
  output logic            JMPmux,
  output logic            PCload,
  output logic            Meminst,
  output logic            MemWr,
  output logic [1:0]      Asel,
  output logic            Aload,
  output logic            Sub,
  output logic            halted,
  output logic [ST_W-1:0] state
);
  typedef enum logic [ST_W-1:0] {
    START  = 4'b0000,
    FETCH  = 4'b0001,
    DECODE = 4'b0010,
    LOAD   = 4'b1000,
    STORE  = 4'b1001,
    ADD    = 4'b1010,
    SUB    = 4'b1011,
    INPUT  = 4'b1100,
    JZ     = 4'b1101,
    JPOS   = 4'b1110,
    HALT   = 4'b1111
  } state_t;
  state_t cur;
`ifdef CU_ENTER_WAIT_EN
  logic in_done;
  assign in_done = enter;
`else
  logic in_done, unused_enter;
  assign in_done = 1'b1;
  assign unused_enter = enter;
`endif
  always_ff @(posedge clk) begin
    if (clear) cur <= START;
    else
      case (cur)
        START:   cur <= FETCH;
        FETCH:   cur <= DECODE;
        DECODE:  cur <= state_t'({1'b1, IR75});
        INPUT:   cur <= in_done ? START : INPUT;
        HALT:    cur <= HALT;
        default: cur <= START;
      endcase
  end
  always_comb begin
    {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, halted} = '0;
    if (!clear)
      case (cur)
        FETCH:  begin IRload = 1'b1; PCload = 1'b1; end
        DECODE: Meminst = 1'b1;
        LOAD:   begin Meminst = 1'b1; Asel = 2'd2; Aload = 1'b1; end
        STORE:  begin Meminst = 1'b1; MemWr = 1'b1; end
        ADD:    begin Meminst = 1'b1; Aload = 1'b1; end
        SUB:    begin Meminst = 1'b1; Aload = 1'b1; Sub = 1'b1; end
        INPUT:  begin Asel = 2'd1; Aload = in_done; end
        JZ:     begin JMPmux = 1'b1; PCload = Aeq0; end
        JPOS:   begin JMPmux = 1'b1; PCload = Apos; end
        HALT:   halted = 1'b1;
        default: ;
      endcase
  end
  assign state = cur;
endmodule

// File: tb/tb_control_unit_fsm.sv
// tb_control_unit_fsm: scoreboard bench for control_unit_fsm; define CU_ENTER_WAIT_EN to test the enter wait.
module tb_control_unit_fsm;
  logic clk = 1'b0, clear = 1'b1, Aeq0 = 1'b0, Apos = 1'b0, enter = 1'b0;
  logic [2:0] IR75 = 3'd0;
  logic IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, halted;
  logic [1:0] Asel;
  logic [3:0] state;
  int tests = 0, fails = 0;
  typedef struct { string tag; logic [13:0] v; } exp_t;
  exp_t q[$];
  localparam logic [9:0] C_NONE  = 10'b0000000000;
  localparam logic [9:0] C_FETCH = 10'b1010000000;
  localparam logic [9:0] C_DEC   = 10'b0001000000;
  localparam logic [9:0] C_LOAD  = 10'b0001010100;
  localparam logic [9:0] C_STORE = 10'b0001100000;
  localparam logic [9:0] C_ADD   = 10'b0001000100;
  localparam logic [9:0] C_SUB   = 10'b0001000110;
  localparam logic [9:0] C_IN    = 10'b0000001100;
  localparam logic [9:0] C_INW   = 10'b0000001000;
  localparam logic [9:0] C_JMP0  = 10'b0100000000;
  localparam logic [9:0] C_JMP1  = 10'b0110000000;
  localparam logic [9:0] C_HALT  = 10'b0000000001;
  control_unit_fsm dut (
    .clk(clk), .clear(clear), .IR75(IR75), .Aeq0(Aeq0), .Apos(Apos), .enter(enter),
    .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr),
    .Asel(Asel), .Aload(Aload), .Sub(Sub), .halted(halted), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got state=%b ctrl=%b, expected state=%b ctrl=%b", tag, got[13:10], got[9:0], exp[13:10], exp[9:0]);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.tag, {state, IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, halted}, e.v);
    end
  task automatic cyc(input logic cl, input logic [2:0] ir, input logic az, input logic ap, input logic en,
                     input string tag, input logic [13:0] exp);
    @(posedge clk); #1;
    clear = cl; IR75 = ir; Aeq0 = az; Apos = ap; enter = en;
    q.push_back('{tag, exp});
  endtask
  function automatic logic [2:0] rnd();
    return 3'($urandom_range(0, 7));
  endfunction
  task automatic front(input logic [2:0] op, input string tag);
    cyc(1'b0, rnd(), 1'b0, 1'b0, 1'b0, {tag, "_start"}, {4'b0000, C_NONE});
    cyc(1'b0, rnd(), 1'b0, 1'b0, 1'b0, {tag, "_fetch"}, {4'b0001, C_FETCH});
    cyc(1'b0, op, 1'b0, 1'b0, 1'b0, {tag, "_decode"}, {4'b0010, C_DEC});
  endtask
  task automatic run_op(input logic [2:0] op, input logic az, input logic ap, input string tag, input logic [13:0] exp);
    front(op, tag);
    cyc(1'b0, rnd(), az, ap, 1'b0, {tag, "_exec"}, exp);
  endtask
  initial begin
    cyc(1'b1, 3'd7, 1'b1, 1'b1, 1'b1, "reset0", {4'b0000, C_NONE});
    cyc(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, "reset1", {4'b0000, C_NONE});
    run_op(3'b010, 1'b0, 1'b0, "add", {4'b1010, C_ADD});
    run_op(3'b011, 1'b0, 1'b0, "sub", {4'b1011, C_SUB});
    run_op(3'b000, 1'b1, 1'b1, "load", {4'b1000, C_LOAD});
    run_op(3'b001, 1'b0, 1'b0, "store", {4'b1001, C_STORE});
    run_op(3'b101, 1'b1, 1'b0, "jz_t", {4'b1101, C_JMP1});
    run_op(3'b101, 1'b0, 1'b1, "jz_f", {4'b1101, C_JMP0});
    run_op(3'b110, 1'b0, 1'b1, "jpos_t", {4'b1110, C_JMP1});
    run_op(3'b110, 1'b1, 1'b0, "jpos_f", {4'b1110, C_JMP0});
    front(3'b100, "input");
`ifdef CU_ENTER_WAIT_EN
    for (int i = 0; i < 5; i++) cyc(1'b0, rnd(), 1'b0, 1'b0, 1'b0, "input_wait", {4'b1100, C_INW});
    cyc(1'b0, rnd(), 1'b0, 1'b0, 1'b1, "input_enter", {4'b1100, C_IN});
`else
    cyc(1'b0, rnd(), 1'b0, 1'b0, 1'b0, "input_exec", {4'b1100, C_IN});
`endif
    front(3'b001, "clr_store");
    cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b0, "clr_store_exec", {4'b1001, C_NONE});
    front(3'b111, "halt");
    for (int i = 0; i < 10; i++) cyc(1'b0, rnd(), i[0], i[1], i[2], "halt_hold", {4'b1111, C_HALT});
    cyc(1'b1, rnd(), 1'b0, 1'b0, 1'b0, "halt_clear", {4'b1111, C_NONE});
    run_op(3'b010, 1'b0, 1'b0, "post_halt", {4'b1010, C_ADD});
    cyc(1'b0, rnd(), 1'b0, 1'b0, 1'b0, "final_start", {4'b0000, C_NONE});
    @(posedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/control_unit_fsm.md
Name: control_unit_fsm

Overview:
- Finite-state controller that sits directly upstream of DataPath.
- Consumes IR75 (opcode), Aeq0 and Apos from DataPath and drives its control inputs: IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub.
- Implements the start -> fetch -> decode -> execute instruction cycle of the 8-bit accumulator processor.
- Adds an operator enter handshake for the input instruction and a halted indicator.

Parameters:
OP_W, 3, opcode width (IR75)
ST_W, 4, state register width

Ports:
clk  input  1  system clock, all state changes on rising edge
clear  input  1  synchronous, active-high reset
IR75  input  OP_W  opcode from DataPath instruction register
Aeq0  input  1  accumulator == 0 flag from DataPath
Apos  input  1  accumulator > 0 flag (positive, not zero) from DataPath
enter  input  1  operator enter key, level, already synchronised
IRload  output  1  load instruction register
JMPmux  output  1  PC source: 0 = PC+1, 1 = IR40
PCload  output  1  load program counter
Meminst  output  1  memory address source: 0 = PC, 1 = IR40
MemWr  output  1  RAM write enable
Asel  output  2  A input select: 0 = adder/subtractor, 1 = in, 2 = RAMout, 3 unused
Aload  output  1  load accumulator
Sub  output  1  ALU: 0 = add, 1 = subtract
halted  output  1  1 while in HALT state
state  output  ST_W  current state code, for debug and display

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock port clk, reset port clear).
- clear sampled high at a rising edge -> state = START (0000) on that edge, regardless of current state, including mid-execute or HALT. While clear is high, all control outputs = 0 and halted = 0.
- Outputs are decoded combinationally from the state register (Moore). Exceptions: PCload in JZ/JPOS, and Aload in INPUT under the macro, also depend on inputs (Mealy).
- State codes: START 0000, FETCH 0001, DECODE 0010, LOAD 1000, STORE 1001, ADD 1010, SUB 1011, INPUT 1100, JZ 1101, JPOS 1110, HALT 1111. Execute state = {1'b1, IR75}.
- Outputs per state (unlisted signals = 0):
  - START: none asserted.
  - FETCH: IRload=1, PCload=1, JMPmux=0.
  - DECODE: Meminst=1.
  - LOAD: Meminst=1, Asel=2, Aload=1.
  - STORE: Meminst=1, MemWr=1.
  - ADD: Meminst=1, Asel=0, Aload=1, Sub=0.
  - SUB: Meminst=1, Asel=0, Aload=1, Sub=1.
  - INPUT: Asel=1, Aload=1.
  - JZ: JMPmux=1, PCload=Aeq0.
  - JPOS: JMPmux=1, PCload=Apos.
  - HALT: halted=1.
- Transitions:
  - START -> FETCH -> DECODE unconditionally.
  - DECODE -> execute state selected by IR75, sampled in the DECODE cycle.
  - Every execute state except HALT -> START on the next edge.
  - HALT -> HALT until clear.
- Instruction latency: 4 cycles (START, FETCH, DECODE, execute), except INPUT under the macro.
- IR75 changes outside DECODE have no effect. Aeq0/Apos are only observed in JZ/JPOS.
- Any unused or illegal state code -> START on the next edge, with all outputs 0 while in it.

Optional Feature:
- Macro: CU_ENTER_WAIT_EN.
- Defined: INPUT holds with Aload = enter and Asel=1. On the edge where enter=1, go to START. While enter=0, stay in INPUT with Aload=0. Instruction latency = 3 + cycles until enter.
- Undefined: INPUT lasts exactly one cycle, Aload=1, and the enter port is ignored.

Test Plan:
1. Hold clear=1 for 2 cycles, then release -> state 0000, then 0001, then 0010. All outputs 0 in START. FETCH shows IRload=1, PCload=1.
2. IR75=010 at DECODE -> next state 1010 with Meminst=1, Aload=1, Asel=0, Sub=0, then 0000. Repeat with IR75=011 -> 1011, Sub=1.
3. IR75=101 with Aeq0=1 -> JZ cycle has JMPmux=1, PCload=1. Repeat with Aeq0=0 -> PCload=0. Repeat with IR75=110 (JPOS) and Apos=1/0 -> PCload follows Apos.
4. IR75=111 -> state 1111, halted=1 for 10 cycles while IR75 is toggled. Then clear=1 -> 0000 and halted=0.
5. With CU_ENTER_WAIT_EN defined, IR75=100 and enter=0 for 5 cycles -> state stays 1100, Aload=0. Raise enter -> Aload=1 that cycle, then 0000. Without the macro -> INPUT lasts 1 cycle with Aload=1.
6. Assert clear during STORE (state 1001) -> MemWr=0 in the clear cycle, next state 0000.
